// File: rtl/axis_tx_pkg.sv
// ============================================================================
// Module      : axis_tx_pkg
// Description : Shared types and helpers for the AXI-Stream packet transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_tx_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    localparam int BEAT_CNT_W   = 16;
    localparam int c_MAX_STRB_W = 128;

    // Callers truncate the result to their own strobe width.
    function automatic logic [c_MAX_STRB_W-1:0] strb_all(input int data_width);
        logic [c_MAX_STRB_W-1:0] v;
        v = '0;
        for (int i = 0; i < c_MAX_STRB_W; i++) begin
            if (i < data_width / 8) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_tx_fifo.sv
// ============================================================================
// Module      : axis_tx_fifo
// Description : Synchronous FIFO with occupancy count and sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_tx_fifo #(
    parameter int  DATA_WIDTH = 32,
    parameter int  FIFO_DEPTH = 16,
    localparam int ADDR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_overflow
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  w_push;
    logic                  w_pop;

    // Full is judged on the current count, so a simultaneous pop never frees room for a push.
    assign o_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_push     = i_wr_en && !o_full;
    assign w_pop      = i_rd_en && !o_empty;
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (i_wr_en && o_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axis_packet_tx.sv
// ============================================================================
// Module      : axis_packet_tx
// Description : AXI-Stream master emitting FIFO words as fixed-length packets.
//               Define AXIS_TX_PKT_CNT_EN to add the pkt_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_packet_tx
    import axis_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_LEN    = 4
) (
    input  logic                           m00_axis_aclk,
    input  logic                           m00_axis_aresetn,
    input  logic                           wr_en,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           wr_full,
    output logic                           wr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    input  logic                           tx_enable,
    output logic                           busy,
    input  logic                           m00_axis_tready,
    output logic [DATA_WIDTH-1:0]          m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]        m00_axis_tstrb,
    output logic                           m00_axis_tvalid,
    output logic                           m00_axis_tlast
`ifdef AXIS_TX_PKT_CNT_EN
    ,
    output logic [31:0]                    pkt_count
`endif
);

    localparam int                    STRB_W      = DATA_WIDTH / 8;
    localparam logic [STRB_W-1:0]     c_STRB_ONES = STRB_W'(strb_all(DATA_WIDTH));
    localparam logic [BEAT_CNT_W-1:0] c_LAST_IDX  = BEAT_CNT_W'(PKT_LEN - 1);

    tx_state_t               r_state;
    tx_state_t               w_state_nxt;
    logic [BEAT_CNT_W-1:0]   r_beat_cnt;
    logic [BEAT_CNT_W-1:0]   w_load_idx;
    logic                    w_xfer;
    logic                    w_load;
    logic                    w_fifo_empty;
    logic [DATA_WIDTH-1:0]   w_fifo_data;
    logic [DATA_WIDTH-1:0]   r_tdata;
    logic [STRB_W-1:0]       r_tstrb;
    logic                    r_tvalid;
    logic                    r_tlast;

    axis_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (m00_axis_aclk),
        .rst_n      (m00_axis_aresetn),
        .i_wr_en    (wr_en),
        .i_wr_data  (wr_data),
        .i_rd_en    (w_load),
        .o_rd_data  (w_fifo_data),
        .o_full     (wr_full),
        .o_empty    (w_fifo_empty),
        .o_count    (fifo_count),
        .o_overflow (wr_overflow)
    );

    assign w_xfer = r_tvalid && m00_axis_tready;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        // Index of the beat that would be loaded now: the in-flight beat leaves on a transfer.
        w_load_idx  = w_xfer ? (r_beat_cnt + BEAT_CNT_W'(1)) : r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (tx_enable && !w_fifo_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_xfer && r_tlast) begin
                    w_state_nxt = IDLE;
                end else if ((!r_tvalid || w_xfer) && !w_fifo_empty) begin
                    w_load = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tdata    <= '0;
            r_tstrb    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_beat_cnt <= r_tlast ? '0 : (r_beat_cnt + BEAT_CNT_W'(1));
            end
            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_fifo_data;
                r_tstrb  <= c_STRB_ONES;
                r_tlast  <= (w_load_idx == c_LAST_IDX);
            end else if (w_xfer) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
        end
    end

`ifdef AXIS_TX_PKT_CNT_EN
    logic [31:0] r_pkt_count;

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_pkt_count <= '0;
        end else if (w_xfer && r_tlast) begin
            r_pkt_count <= r_pkt_count + 32'd1;
        end
    end

    assign pkt_count = r_pkt_count;
`endif

    assign busy            = (r_state == SEND);
    assign m00_axis_tdata  = r_tdata;
    assign m00_axis_tstrb  = r_tstrb;
    assign m00_axis_tvalid = r_tvalid;
    assign m00_axis_tlast  = r_tlast;

endmodule

`default_nettype wire

// File: tb/tb_axis_packet_tx.sv
// ============================================================================
// Module      : tb_axis_packet_tx
// Description : Scoreboard bench for axis_packet_tx (PKT_LEN=4 and PKT_LEN=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_packet_tx;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_full, wr_overflow, busy;
    logic [4:0]  fifo_count;
    logic        tx_enable = 1'b0;
    logic        tready = 1'b0;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tvalid, tlast;

    logic        wr_en1 = 1'b0;
    logic [31:0] wr_data1 = '0;
    logic        wr_full1, wr_overflow1, busy1;
    logic [2:0]  fifo_count1;
    logic        tx_en1 = 1'b0;
    logic        tready1 = 1'b0;
    logic [31:0] tdata1;
    logic [3:0]  tstrb1;
    logic        tvalid1, tlast1;

`ifdef AXIS_TX_PKT_CNT_EN
    logic [31:0] pkt_count, pkt_count1;
`endif

    int    vectors = 0;
    int    miscompares = 0;
    beat_t exp_q[$];
    logic [31:0] q1[$];
    int    exp_idx = 0;
    int    tr_mode = 0;
    int    pat_i = 0;

    always #5 clk = ~clk;

    axis_packet_tx #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .PKT_LEN(4)) u_dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst_n),
        .wr_en            (wr_en),
        .wr_data          (wr_data),
        .wr_full          (wr_full),
        .wr_overflow      (wr_overflow),
        .fifo_count       (fifo_count),
        .tx_enable        (tx_enable),
        .busy             (busy),
        .m00_axis_tready  (tready),
        .m00_axis_tdata   (tdata),
        .m00_axis_tstrb   (tstrb),
        .m00_axis_tvalid  (tvalid),
        .m00_axis_tlast   (tlast)
`ifdef AXIS_TX_PKT_CNT_EN
        ,
        .pkt_count        (pkt_count)
`endif
    );

    axis_packet_tx #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .PKT_LEN(1)) u_dut_p1 (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst_n),
        .wr_en            (wr_en1),
        .wr_data          (wr_data1),
        .wr_full          (wr_full1),
        .wr_overflow      (wr_overflow1),
        .fifo_count       (fifo_count1),
        .tx_enable        (tx_en1),
        .busy             (busy1),
        .m00_axis_tready  (tready1),
        .m00_axis_tdata   (tdata1),
        .m00_axis_tstrb   (tstrb1),
        .m00_axis_tvalid  (tvalid1),
        .m00_axis_tlast   (tlast1)
`ifdef AXIS_TX_PKT_CNT_EN
        ,
        .pkt_count        (pkt_count1)
`endif
    );

    // Main monitor: pops one expected beat per handshake and checks stall stability.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        beat_t       e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    vectors++;
                    if (!(tvalid === 1'b1 && tdata === prev_data && tlast === prev_last)) begin
                        miscompares++;
                        $display("FAIL stall_hold: tvalid=%b tdata=%h tlast=%b, required tvalid=1 tdata=%h tlast=%b",
                                 tvalid, tdata, tlast, prev_data, prev_last);
                    end
                end
                if (tvalid && tready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL beat_unexpected: tdata=%h tlast=%b, required no beat", tdata, tlast);
                    end else begin
                        e = exp_q.pop_front();
                        if (tdata !== e.data || tlast !== e.last || tstrb !== 4'hF) begin
                            miscompares++;
                            $display("FAIL beat: tdata=%h tlast=%b tstrb=%h, required tdata=%h tlast=%b tstrb=f",
                                     tdata, tlast, tstrb, e.data, e.last);
                        end
                    end
                end
                prev_stall = tvalid && !tready;
                prev_data  = tdata;
                prev_last  = tlast;
            end
        end
    end

    // PKT_LEN=1 monitor: every beat carries tlast.
    initial begin
        logic [31:0] d;
        forever begin
            @(negedge clk);
            if (rst_n && tvalid1 && tready1) begin
                vectors++;
                if (q1.size() == 0) begin
                    miscompares++;
                    $display("FAIL p1_unexpected: tdata=%h, required no beat", tdata1);
                end else begin
                    d = q1.pop_front();
                    if (tdata1 !== d || tlast1 !== 1'b1) begin
                        miscompares++;
                        $display("FAIL p1_beat: tdata=%h tlast=%b, required tdata=%h tlast=1", tdata1, tlast1, d);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (tr_mode)
            0: tready = 1'b1;
            1: begin
                tready = (pat_i == 0);
                pat_i  = (pat_i + 1) % 3;
            end
            default: tready = 1'b0;
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] d, input bit accepted);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        if (accepted) begin
            exp_q.push_back('{data: d, last: (exp_idx == 3)});
            exp_idx = (exp_idx + 1) % 4;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tvalid) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: %0d beats outstanding, required 0", name, exp_q.size());
        end
        tick();
    endtask

    initial begin
        // Reset values
        tick(); tick(); tick();
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_tlast", {31'd0, tlast}, 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_tstrb", {28'd0, tstrb}, 32'd0);
        check("rst_overflow", {31'd0, wr_overflow}, 32'd0);
        check("rst_count", {27'd0, fifo_count}, 32'd0);
        check("rst_full", {31'd0, wr_full}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: back-to-back packet with tready held high
        tx_enable = 1'b1;
        tr_mode   = 0;
        tready    = 1'b1;
        push(32'h11, 1'b1);
        push(32'h22, 1'b1);
        check("latency_tvalid", {31'd0, tvalid}, 32'd1);
        check("latency_tdata", tdata, 32'h11);
        push(32'h33, 1'b1);
        push(32'h44, 1'b1);
        wait_drain("t1");
        check("t1_busy_idle", {31'd0, busy}, 32'd0);

        // 2: eight words under a 1,0,0 tready pattern
        tr_mode = 1;
        pat_i   = 0;
        for (int i = 0; i < 8; i++) push(32'hA0 + i, 1'b1);
        wait_drain("t2");

        // 3: fill to full with the output stalled, overflow on the 17th push
        tx_enable = 1'b0;
        tr_mode   = 2;
        for (int i = 0; i < 15; i++) push(32'h300 + i, 1'b1);
        check("t3_count15", {27'd0, fifo_count}, 32'd15);
        check("t3_full15", {31'd0, wr_full}, 32'd0);
        push(32'h30F, 1'b1);
        check("t3_count16", {27'd0, fifo_count}, 32'd16);
        check("t3_full16", {31'd0, wr_full}, 32'd1);
        check("t3_ovf_before", {31'd0, wr_overflow}, 32'd0);
        push(32'h310, 1'b0);
        check("t3_ovf_after", {31'd0, wr_overflow}, 32'd1);
        check("t3_count_held", {27'd0, fifo_count}, 32'd16);
        tx_enable = 1'b1;
        tr_mode   = 0;
        wait_drain("t3");
        check("t3_ovf_sticky", {31'd0, wr_overflow}, 32'd1);
        check("t3_full_clear", {31'd0, wr_full}, 32'd0);

        // 4: tx_enable dropped after two beats of a packet
        tx_enable = 1'b0;
        for (int i = 0; i < 8; i++) push(32'h40 + i, 1'b1);
        check("t4_count8", {27'd0, fifo_count}, 32'd8);
        tr_mode   = 2;
        tready    = 1'b0;
        tx_enable = 1'b1;
        tick();
        tr_mode   = 0;
        tready    = 1'b1;
        tick();
        tick();
        tx_enable = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("t4_stopped_tvalid", {31'd0, tvalid}, 32'd0);
        check("t4_stopped_busy", {31'd0, busy}, 32'd0);
        check("t4_count_left", {27'd0, fifo_count}, 32'd4);
        check("t4_exp_left", exp_q.size(), 32'd4);
        tx_enable = 1'b1;
        wait_drain("t4");

        // 5: reset while a beat is stalled on the bus
        tr_mode = 2;
        tready  = 1'b0;
        push(32'h50, 1'b1);
        push(32'h51, 1'b1);
        push(32'h52, 1'b1);
        check("t5_tvalid_pre", {31'd0, tvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("t5_rst_count", {27'd0, fifo_count}, 32'd0);
        check("t5_rst_tlast", {31'd0, tlast}, 32'd0);
        exp_q.delete();
        exp_idx = 0;
        tick();
        tick();
        rst_n   = 1'b1;
        tr_mode = 0;
        tready  = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h60 + i, 1'b1);
        wait_drain("t5");

        // 6: two more packets, then PKT_LEN=1 instance
        for (int i = 0; i < 8; i++) push(32'h70 + i, 1'b1);
        wait_drain("t6");
`ifdef AXIS_TX_PKT_CNT_EN
        check("t6_pkt_count", pkt_count, 32'd3);
`endif
        tx_en1  = 1'b1;
        tready1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en1   = 1'b1;
            wr_data1 = 32'h81 + i;
            tick();
            q1.push_back(32'h81 + i);
        end
        wr_en1 = 1'b0;
        begin
            int n;
            n = 0;
            while ((q1.size() != 0 || tvalid1) && n < 100) begin
                tick();
                n++;
            end
            if (n >= 100) begin
                vectors++;
                miscompares++;
                $display("FAIL p1_timeout: %0d beats outstanding, required 0", q1.size());
            end
        end
        tick();
`ifdef AXIS_TX_PKT_CNT_EN
        check("p1_pkt_count", pkt_count1, 32'd3);
`endif
        check("p1_busy_idle", {31'd0, busy1}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
